mem_port_arbiter: RTL and testbench

Shares one single-ported, fixed-latency unified memory between the pipeline's instruction-fetch stage and its memory stage. It grants one access at a time, gives data accesses priority over fetches, and drives per-requester stall signals. The hazard unit ORs these stalls into its freeze logic. The block sits between the pipeline datapath and the memory model, inside the CPU top.

---
 rtl/mem_port_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and data access; data wins ties.
// Optional fetch-conflict performance counter is enabled with `define MEM_ARB_PERF_EN.
module mem_port_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_valid,
  output logic          stall_if,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_valid,
  output logic          stall_mem,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [15:0]   conflict_cnt
);

  localparam int CW = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_BUSY_I = 2'd1;
  localparam logic [1:0] ST_BUSY_D = 2'd2;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_wdrawn;

  logic w_idle;
  logic w_issue_d;
  logic w_issue_i;
  logic w_done;
  logic w_owner_req;

  always_comb begin
    w_idle      = (r_state == ST_IDLE);
    w_issue_d   = w_idle & d_req;
    w_issue_i   = w_idle & ~d_req & i_req;
    w_done      = ~w_idle & (r_cnt == CW'(1));
    w_owner_req = (r_state == ST_BUSY_D) ? d_req : i_req;
  end

  // r_wdrawn remembers that the owner dropped its request, so a fresh request
  // raised in the completion cycle does not pick up the flushed access's data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_wdrawn <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue_d) begin
            r_state  <= ST_BUSY_D;
            r_cnt    <= CW'(MEM_LAT);
            r_wdrawn <= 1'b0;
          end else if (w_issue_i) begin
            r_state  <= ST_BUSY_I;
            r_cnt    <= CW'(MEM_LAT);
            r_wdrawn <= 1'b0;
          end
        end
        default: begin
          r_cnt <= r_cnt - CW'(1);
          if (!w_owner_req) r_wdrawn <= 1'b1;
          if (w_done) r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // All outputs are forced low while reset is asserted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_valid   = 1'b0;
    i_rdata   = '0;
    d_valid   = 1'b0;
    d_rdata   = '0;
    stall_if  = 1'b0;
    stall_mem = 1'b0;
    if (!rst) begin
      mem_en = w_issue_d | w_issue_i;
      if (w_issue_d) begin
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
      end else if (w_issue_i) begin
        mem_addr  = i_addr;
      end
      if (w_done && r_state == ST_BUSY_I) begin
        i_valid = i_req & ~r_wdrawn;
        i_rdata = mem_rdata;
      end
      if (w_done && r_state == ST_BUSY_D) begin
        d_valid = d_req & ~r_wdrawn;
        d_rdata = mem_rdata;
      end
      stall_if  = i_req & ~i_valid;
      stall_mem = d_req & ~d_valid;
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic [15:0] r_conflict;
  logic        w_conflict_hit;

  assign w_conflict_hit = i_req & stall_if & (d_req | (r_state == ST_BUSY_D));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_conflict <= '0;
    end else if (w_conflict_hit && r_conflict != 16'hFFFF) begin
      r_conflict <= r_conflict + 16'd1;
    end
  end

  assign conflict_cnt = rst ? 16'd0 : r_conflict;
`else
  assign conflict_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random requesters,
// compared every cycle against a cycle-count based reference model and a memory stub.
module tb_mem_port_arbiter;

  localparam int MEM_LAT = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_valid;
  logic          stall_if;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_valid;
  logic          stall_mem;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic [15:0]   conflict_cnt;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid), .stall_if(stall_if),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .conflict_cnt(conflict_cnt)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: an access issued in cycle c owns memory through cycle c+MEM_LAT.
  int          cyc = 0;
  int          busyUntil = -1;
  int          owner = 0;
  bit          wdrawn = 1'b0;
  logic [31:0] pendData = '0;
  bit          pendWrite = 1'b0;
  logic [15:0] refConflict = '0;
  bit          lastIvalid = 1'b0;
  logic [31:0] refMem [logic [31:0]];

  logic [31:0] stubMem [logic [31:0]];
  typedef struct {int due; logic [31:0] data;} rd_t;
  rd_t rdQ[$];

  function automatic logic [31:0] initWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function logic [31:0] readRef(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function logic [31:0] readStub(input logic [31:0] a);
    return stubMem.exists(a) ? stubMem[a] : initWord(a);
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic checkOutput();
    bit          free, compl, issD, issI, expIv, expDv, expSi, expSm, expEn, expWe;
    logic [31:0] expAddr, expWd, expIr, expDr;
    logic [15:0] expCnt;
    free = 0; compl = 0; issD = 0; issI = 0; expIv = 0; expDv = 0; expSi = 0; expSm = 0;
    expEn = 0; expWe = 0; expAddr = '0; expWd = '0; expIr = '0; expDr = '0; expCnt = '0;
    if (!rst) begin
      free  = (cyc > busyUntil);
      compl = !free && (cyc == busyUntil);
      issD  = free && d_req;
      issI  = free && !d_req && i_req;
      expEn = issD || issI;
      expWe = issD && d_we;
      expAddr = issD ? d_addr : (issI ? i_addr : 32'h0);
      expWd   = issD ? d_wdata : 32'h0;
      if (compl && owner == 1) begin
        expIv = i_req && !wdrawn;
        expIr = pendData;
      end
      if (compl && owner == 2) begin
        expDv = d_req && !wdrawn;
        expDr = pendWrite ? mem_rdata : pendData;
      end
      expSi = i_req && !expIv;
      expSm = d_req && !expDv;
`ifdef MEM_ARB_PERF_EN
      expCnt = refConflict;
`endif
    end
    checkVal("mem_en", {63'd0, mem_en}, {63'd0, expEn});
    checkVal("mem_we", {63'd0, mem_we}, {63'd0, expWe});
    checkVal("mem_addr", {32'd0, mem_addr}, {32'd0, expAddr});
    checkVal("mem_wdata", {32'd0, mem_wdata}, {32'd0, expWd});
    checkVal("i_valid", {63'd0, i_valid}, {63'd0, expIv});
    checkVal("i_rdata", {32'd0, i_rdata}, {32'd0, expIr});
    checkVal("d_valid", {63'd0, d_valid}, {63'd0, expDv});
    checkVal("d_rdata", {32'd0, d_rdata}, {32'd0, expDr});
    checkVal("stall_if", {63'd0, stall_if}, {63'd0, expSi});
    checkVal("stall_mem", {63'd0, stall_mem}, {63'd0, expSm});
    checkVal("conflict_cnt", {48'd0, conflict_cnt}, {48'd0, expCnt});
    lastIvalid = expIv;
    if (rst) begin
      busyUntil = -1;
      owner = 0;
      wdrawn = 0;
      refConflict = '0;
    end else begin
      if (i_req && expSi && (d_req || (!free && owner == 2)) && refConflict != 16'hFFFF)
        refConflict++;
      if (!free && ((owner == 1 && !i_req) || (owner == 2 && !d_req))) wdrawn = 1;
      if (issD || issI) begin
        busyUntil = cyc + MEM_LAT;
        owner = issD ? 2 : 1;
        wdrawn = 0;
        pendWrite = issD && d_we;
        if (issD && d_we) refMem[d_addr] = d_wdata;
        else pendData = readRef(issD ? d_addr : i_addr);
      end
    end
    // Memory stub reacts to what the DUT actually drives.
    if (mem_en) begin
      if (mem_we) stubMem[mem_addr] = mem_wdata;
      else rdQ.push_back('{cyc + MEM_LAT, readStub(mem_addr)});
    end
    cyc++;
  endtask

  task automatic applyStimulus(input bit r, input bit ir, input logic [31:0] ia,
                               input bit dr, input bit dw, input logic [31:0] da,
                               input logic [31:0] dwd);
    @(posedge clk);
    #1;
    rst = r; i_req = ir; i_addr = ia; d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
    if (rdQ.size() > 0 && rdQ[0].due == cyc) begin
      mem_rdata = rdQ[0].data;
      void'(rdQ.pop_front());
    end else begin
      mem_rdata = $urandom;
    end
    @(negedge clk);
    checkOutput();
  endtask

  bit          ir, dr, dw;
  logic [31:0] ia, da, dwd;

  initial begin
    rst = 1; i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    ir = 0; dr = 0; dw = 0; ia = 0; da = 0; dwd = 0;

    // Reset: requests present but every output held low.
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 32'h10, 1, 0, 32'h40, 0);
    checkVal("rst_stall_if", {63'd0, stall_if}, 64'd0);
    checkVal("rst_mem_en", {63'd0, mem_en}, 64'd0);

    // Simultaneous requests: D first, then I.
    applyStimulus(0, 1, 32'h44, 1, 0, 32'h40, 0);
    checkVal("sim_d_addr", {32'd0, mem_addr}, 64'h40);
    applyStimulus(0, 1, 32'h44, 1, 0, 32'h40, 0);
    applyStimulus(0, 1, 32'h44, 1, 0, 32'h40, 0);
    checkVal("sim_d_valid", {63'd0, d_valid}, 64'd1);
    checkVal("sim_d_rdata", {32'd0, d_rdata}, {32'd0, initWord(32'h40)});
    applyStimulus(0, 1, 32'h44, 0, 0, 0, 0);
    checkVal("sim_i_issue", {32'd0, mem_addr}, 64'h44);
`ifdef MEM_ARB_PERF_EN
    checkVal("sim_conflict", {48'd0, conflict_cnt}, 64'd3);
`else
    checkVal("sim_conflict", {48'd0, conflict_cnt}, 64'd0);
`endif
    applyStimulus(0, 1, 32'h44, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h44, 0, 0, 0, 0);
    checkVal("sim_i_rdata", {32'd0, i_rdata}, {32'd0, initWord(32'h44)});
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Single fetch.
    applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
    checkVal("fetch_we", {63'd0, mem_we}, 64'd0);
    applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h10, 0, 0, 0, 0);
    checkVal("fetch_valid", {63'd0, i_valid}, 64'd1);
    checkVal("fetch_rdata", {32'd0, i_rdata}, {32'd0, initWord(32'h10)});
    applyStimulus(0, 0, 0, 1, 0, 32'h14, 0);
    checkVal("fetch_idle_again", {63'd0, mem_en}, 64'd1);
    applyStimulus(0, 0, 0, 1, 0, 32'h14, 0);
    applyStimulus(0, 0, 0, 1, 0, 32'h14, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Store then fetch the same word.
    applyStimulus(0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF);
    checkVal("store_we", {63'd0, mem_we}, 64'd1);
    checkVal("store_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    applyStimulus(0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 1, 1, 32'h80, 32'hDEADBEEF);
    checkVal("store_valid", {63'd0, d_valid}, 64'd1);
    applyStimulus(0, 1, 32'h80, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h80, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h80, 0, 0, 0, 0);
    checkVal("store_readback", {32'd0, i_rdata}, 64'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Flush: fetch withdrawn, a new one raised in the completion cycle.
    applyStimulus(0, 1, 32'h20, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h24, 0, 0, 0, 0);
    checkVal("flush_no_valid", {63'd0, i_valid}, 64'd0);
    applyStimulus(0, 1, 32'h24, 0, 0, 0, 0);
    checkVal("flush_reissue", {32'd0, mem_addr}, 64'h24);
    applyStimulus(0, 1, 32'h24, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h24, 0, 0, 0, 0);
    checkVal("flush_new_rdata", {32'd0, i_rdata}, {32'd0, initWord(32'h24)});
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a data read.
    applyStimulus(0, 0, 0, 1, 0, 32'h48, 0);
    applyStimulus(1, 0, 0, 1, 0, 32'h48, 0);
    checkVal("rstmid_stall_mem", {63'd0, stall_mem}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    checkVal("rstmid_no_valid", {63'd0, d_valid}, 64'd0);
    checkVal("rstmid_rdata", {32'd0, d_rdata}, 64'd0);
    applyStimulus(0, 1, 32'h4C, 0, 0, 0, 0);
    checkVal("rstmid_next_issue", {63'd0, mem_en}, 64'd1);
    applyStimulus(0, 1, 32'h4C, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h4C, 0, 0, 0, 0);
    checkVal("rstmid_next_valid", {63'd0, i_valid}, 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Random requesters that hold until valid and occasionally flush.
    for (int n = 0; n < 3000; n++) begin
      if (ir && !lastIvalid) begin
        if ($urandom_range(0, 15) == 0) ir = 0;
      end else begin
        ir = ($urandom_range(0, 2) != 0);
        ia = 32'($urandom_range(0, 15)) * 32'd4;
      end
      if (dr && !d_valid) begin
        if ($urandom_range(0, 15) == 0) dr = 0;
      end else begin
        dr = ($urandom_range(0, 3) == 0);
        dw = ($urandom_range(0, 1) != 0);
        da = 32'($urandom_range(0, 15)) * 32'd4;
        dwd = $urandom;
      end
      applyStimulus(0, ir, ia, dr, dw, da, dwd);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    // Continuous data traffic starves the fetch port.
`ifdef MEM_ARB_PERF_EN
    for (int n = 0; n < 70000; n++) applyStimulus(0, 1, 32'h30, 1, 0, 32'h34, 0);
    checkVal("sat_conflict", {48'd0, conflict_cnt}, 64'hFFFF);
`else
    for (int n = 0; n < 30; n++) applyStimulus(0, 1, 32'h30, 1, 0, 32'h34, 0);
    checkVal("starve_conflict", {48'd0, conflict_cnt}, 64'd0);
`endif
    checkVal("starve_stall_if", {63'd0, stall_if}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
